// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes,
// and the datapath mux / ALU / immediate select encodings.
// Latency: n/a (package). Backpressure: n/a.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // State entered after DECODE; S_FETCH marks an unsupported opcode.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_R:         nxt = S_EXECUTER;
      OP_I:         nxt = S_EXECUTEI;
      OP_JAL:       nxt = S_JAL;
      OP_BEQ:       nxt = S_BEQ;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/immdec.sv
// Immediate-format select decoded from the opcode.
// Latency: combinational. Backpressure: none.
// Ports: op (opcode) in, ImmSrc (immediate format select) out.
module immdec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: Moore outputs per state, with MemReady/Zero strobes.
// Latency: FETCH-to-FETCH lw 5, sw/R/I/jal 4, beq 3 cycles with zero memory wait.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold MemReq until MemReady; MemReady elsewhere ignored.
// Ports: clk, rst_n; op, Zero, MemReady in; MemReq, MemWrite, AdrSrc, IRWrite, PCWrite,
//   RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, InstrDone, IllegalOp out.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       InstrDone,
  output logic       IllegalOp
);

  state_t state;
  state_t state_nxt;

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_op;

  immdec u_immdec (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    state_nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE:   state_nxt = decode_next(op);
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_BEQ:      state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 is computed while the fetch is outstanding; IR/PC load only on completion.
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = MemReady;
        pc_write   = MemReady;
      end
      S_DECODE: begin
        // Branch/jump target OldPC+imm is precomputed here.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        illegal_op = (decode_next(op) == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = MemReady;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC <- target (ALUOut from DECODE) while ALU forms the link value OldPC+4.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        pc_write   = Zero;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset also masks the decoded outputs so an outstanding MemReq drops
  // immediately rather than at the next clock edge.
  assign MemReq    = mem_req    & rst_n;
  assign MemWrite  = mem_write  & rst_n;
  assign AdrSrc    = adr_src    & rst_n;
  assign IRWrite   = ir_write   & rst_n;
  assign PCWrite   = pc_write   & rst_n;
  assign RegWrite  = reg_write  & rst_n;
  assign ResultSrc = result_src & {2{rst_n}};
  assign ALUSrcA   = alu_src_a  & {2{rst_n}};
  assign ALUSrcB   = alu_src_b  & {2{rst_n}};
  assign ALUOp     = alu_op     & {2{rst_n}};
  assign InstrDone = instr_done & rst_n;
  assign IllegalOp = illegal_op & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output signatures against hand-built constants.
// Latency: n/a. Backpressure: MemReady stalls driven explicitly.
// Ports: none (top-level bench).
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       InstrDone, IllegalOp;

  int n_chk = 0;
  int n_err = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .InstrDone (InstrDone),
    .IllegalOp (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signature layout: MemReq MemWrite AdrSrc IRWrite PCWrite RegWrite
  //                   ResultSrc[2] ALUSrcA[2] ALUSrcB[2] ALUOp[2] InstrDone IllegalOp
  logic [15:0] sig;
  assign sig = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, InstrDone, IllegalOp};

  localparam logic [15:0] X_ZERO      = 16'h0000;
  localparam logic [15:0] X_FETCH_W   = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] X_FETCH_GO  = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] X_DECODE    = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] X_DEC_ILL   = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
  localparam logic [15:0] X_MEMADR    = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] X_MEMREAD   = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] X_MEMWB     = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] X_MEMWR_W   = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] X_MEMWR_GO  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] X_EXECR     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] X_EXECI     = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
  localparam logic [15:0] X_ALUWB     = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] X_JAL       = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] X_BEQ_Z     = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  localparam logic [15:0] X_BEQ_NZ    = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive this cycle's strobes just after the edge, check outputs, advance one cycle.
  task automatic cyc(input logic rdy, input logic z, input logic [15:0] exp, input string tag);
    MemReady = rdy;
    Zero     = z;
    #1;
    chk(tag, sig, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    op       = 7'b1101111;
    Zero     = 1'b0;
    MemReady = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_outputs", sig, X_ZERO);
    chk("rst_immsrc_jal", {14'd0, ImmSrc}, 16'd3);
    op = 7'b0000011;
    rst_n = 1'b1;

    // lw, zero wait: 5 cycles
    cyc(1, 0, X_FETCH_GO, "lw_fetch");
    cyc(1, 0, X_DECODE,   "lw_decode");
    cyc(1, 0, X_MEMADR,   "lw_memadr");
    cyc(1, 0, X_MEMREAD,  "lw_memread");
    chk("lw_immsrc", {14'd0, ImmSrc}, 16'd0);
    cyc(1, 0, X_MEMWB,    "lw_memwb");

    // sw with three MemReady-low cycles in MEMWRITE
    op = 7'b0100011;
    cyc(1, 0, X_FETCH_GO, "sw_fetch");
    cyc(1, 0, X_DECODE,   "sw_decode");
    chk("sw_immsrc", {14'd0, ImmSrc}, 16'd1);
    cyc(0, 0, X_MEMADR,   "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(0, 0, X_MEMWR_W, $sformatf("sw_wait%0d", i));
    cyc(1, 0, X_MEMWR_GO, "sw_memwrite_done");

    // R-type with one fetch stall
    op = 7'b0110011;
    cyc(0, 0, X_FETCH_W,  "r_fetch_wait");
    cyc(1, 0, X_FETCH_GO, "r_fetch");
    cyc(1, 0, X_DECODE,   "r_decode");
    cyc(1, 0, X_EXECR,    "r_exec");
    chk("r_immsrc", {14'd0, ImmSrc}, 16'd0);
    cyc(1, 0, X_ALUWB,    "r_aluwb");

    // I-type
    op = 7'b0010011;
    cyc(1, 0, X_FETCH_GO, "i_fetch");
    cyc(1, 0, X_DECODE,   "i_decode");
    cyc(1, 0, X_EXECI,    "i_exec");
    cyc(1, 0, X_ALUWB,    "i_aluwb");

    // beq taken, then not taken
    op = 7'b1100011;
    cyc(1, 0, X_FETCH_GO, "beq1_fetch");
    cyc(1, 0, X_DECODE,   "beq1_decode");
    chk("beq_immsrc", {14'd0, ImmSrc}, 16'd2);
    cyc(1, 1, X_BEQ_Z,    "beq_taken");
    cyc(1, 0, X_FETCH_GO, "beq2_fetch");
    cyc(1, 0, X_DECODE,   "beq2_decode");
    cyc(1, 0, X_BEQ_NZ,   "beq_not_taken");

    // jal
    op = 7'b1101111;
    cyc(1, 0, X_FETCH_GO, "jal_fetch");
    cyc(1, 0, X_DECODE,   "jal_decode");
    cyc(1, 0, X_JAL,      "jal_jal");
    chk("jal_immsrc", {14'd0, ImmSrc}, 16'd3);
    cyc(1, 0, X_ALUWB,    "jal_aluwb");

    // illegal opcode
    op = 7'b1111111;
    cyc(1, 0, X_FETCH_GO, "ill_fetch");
    cyc(1, 0, X_DEC_ILL,  "ill_decode");
    cyc(0, 0, X_FETCH_W,  "ill_back_to_fetch");

    // reset during an outstanding MEMREAD request
    op = 7'b0000011;
    cyc(1, 0, X_FETCH_GO, "rst_lw_fetch");
    cyc(1, 0, X_DECODE,   "rst_lw_decode");
    cyc(0, 0, X_MEMADR,   "rst_lw_memadr");
    MemReady = 1'b0;
    #1;
    chk("rst_lw_memread", sig, X_MEMREAD);
    rst_n = 1'b0;
    #1;
    chk("rst_memreq_drop", sig, X_ZERO);
    @(posedge clk);
    #1;
    chk("rst_held", sig, X_ZERO);
    rst_n = 1'b1;
    cyc(0, 0, X_FETCH_W,  "post_rst_fetch");
    cyc(1, 0, X_FETCH_GO, "post_rst_fetch_go");
    cyc(1, 0, X_DECODE,   "post_rst_decode");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op  in  7  opcode from instruction register; stable from DECODE to instruction end.
REQ-005 Zero  in  1  ALU zero flag, sampled in BEQ.
REQ-006 MemReady  in  1  memory completion strobe for the current MemReq cycle.
REQ-007 MemReq  out  1  memory access request; held until MemReady.
REQ-008 MemWrite  out  1  store strobe, qualifies MemReq.
REQ-009 AdrSrc  out  1  address mux: 0 = PC, 1 = Result.
REQ-010 IRWrite  out  1  instruction register and OldPC load enable.
REQ-011 PCWrite  out  1  PC load enable.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-014 ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1.
REQ-015 ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-016 ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded.
REQ-017 ImmSrc  out  2  lw/I-type 00, sw 01, beq 10, jal 11, R-type 00, others 00.
REQ-018 InstrDone  out  1  one-cycle pulse on the last cycle of each legal instruction.
REQ-019 IllegalOp  out  1  one-cycle pulse in DECODE for unsupported op.

Function
REQ-020 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ; outputs not listed for a state SHALL be 0.
REQ-021 FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; hold while MemReady=0; when MemReady=1, IRWrite=1 and PCWrite=1 that cycle only, next DECODE.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1101111 JAL, 1100011 BEQ; any other op: IllegalOp=1, next FETCH.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD for lw, MEMWRITE for sw.
REQ-024 MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00; hold until MemReady, then MEMWB.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1; next FETCH.
REQ-026 MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00; hold until MemReady; InstrDone=1 in the MemReady cycle; next FETCH.
REQ-027 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next ALUWB.
REQ-028 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; next ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1; next FETCH.
REQ-030 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-031 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, InstrDone=1; next FETCH.
REQ-032 Zero-wait latency SHALL be lw 5, sw/R/I/jal 4, beq 3 cycles, FETCH to FETCH.
REQ-033 MemWrite, IRWrite, PCWrite and RegWrite SHALL never assert together with an unresolved MemReq other than as stated in REQ-021/026.
REQ-034 MemReady outside a MemReq cycle SHALL be ignored.
REQ-035 ImmSrc SHALL be combinational from op, valid in every state.

Reset
REQ-036 rst_n low SHALL force state to FETCH immediately and all outputs except ImmSrc to 0, including mid-instruction and during an outstanding MemReq.
REQ-037 First rising edge after rst_n release SHALL find FETCH with MemReq=1.

Structure
REQ-038 Shared package mc_pkg SHALL hold the state enum, opcode constants, and ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings.
REQ-039 One sub-module, immdec (op to ImmSrc), SHALL be instantiated; the FSM SHALL be a registered state with combinational Moore outputs, except MemReady/Zero-qualified strobes.

Verification
REQ-040 Reset, MemReady=1, op=0000011 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5 only.
REQ-041 op=0100011, MemReady low 3 cycles in MEMWRITE -> MemReq=MemWrite=1 held 4 cycles, InstrDone on 4th, no RegWrite.
REQ-042 op=1100011, Zero=1 then Zero=0 -> PCWrite=1 in BEQ first, 0 second; ALUOp=01 both.
REQ-043 op=1101111 -> PCWrite in FETCH and JAL, RegWrite in ALUWB, ImmSrc=11.
REQ-044 op=1111111 -> IllegalOp pulse in DECODE, next FETCH, no RegWrite/MemWrite.
REQ-045 rst_n low during MEMREAD with MemReq=1 -> MemReq drops same cycle; after release FETCH.
